imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the 256-word instruction memory read by the fetch stage. Accepts a framed byte stream (magic, word count, big-endian instruction words, XOR checksum) over a valid/ready handshake, packs bytes into 32-bit words and writes them at consecutive word addresses from 0. Holds the CPU in reset (`cpu_rstd` low) until a frame loads with a correct checksum, then releases it so the first fetch at pc 0 sees the loaded program.

## Interface
- `AW`, 8, instruction-memory word-address width; matches the 8-bit pc index.
- `MAGIC`, 8'hA5, frame start byte.
- `clk`  in  1  clock.
- `rstd`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  byte-stream source has a byte.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle; a transfer occurs at a posedge where `in_valid && in_ready`.
- `im_we`  out  1  instruction-memory write strobe; memory writes on the posedge where it is high.
- `im_addr`  out  AW  word address.
- `im_wdata`  out  32  instruction word.
- `cpu_rstd`  out  1  active-low reset to the CPU core; low while loading.
- `done`  out  1  sticky; load completed with a good checksum.
- `err`  out  1  last frame failed its checksum.

## Operation
- States: S_MAGIC, S_COUNT, S_DATA, S_WRITE, S_CHECK, S_RUN, S_ERR.
- S_MAGIC: on each accepted byte, equal to MAGIC -> S_COUNT; otherwise discard and stay (resync).
- S_COUNT: accepted byte N sets the word count; N=0 means 256 words. Clear byte index, checksum accumulator and `im_addr` -> S_DATA.
- S_DATA: accept bytes MSB first into a shift register (`wdata <= {wdata[23:0], in_data}`). XOR every data byte into the 8-bit checksum. On the 4th byte -> S_WRITE.
- S_WRITE, 1 cycle: `im_we`=1 with the assembled word on `im_wdata` and the current `im_addr`. At exit, `im_addr` increments (wraps modulo 2^AW) and the remaining-word count decrements. Count reaching 0 -> S_CHECK, else -> S_DATA.
- S_CHECK: compare the accepted byte with the accumulator. Equal -> S_RUN. Unequal -> S_ERR.
- S_RUN: `cpu_rstd`=1, `done`=1, `in_ready`=0. Terminal until `rstd`.
- S_ERR: `err`=1, `cpu_rstd` stays 0. `in_ready`=1. An accepted MAGIC byte clears `err` and goes to S_COUNT. Other bytes are discarded.
- `in_ready` = 1 in S_MAGIC, S_COUNT, S_DATA, S_CHECK, S_ERR; 0 in S_WRITE and S_RUN.
- Data written before an error stays in memory. A retry overwrites it from address 0.
- Remaining-word counter is 9 bits so N=0 loads 256 words. Addresses run 0..255, then the count ends.

## Timing
- Reset (async, `rstd`=0): state S_MAGIC, `in_ready`=1, `im_we`=0, `im_addr`=0, `im_wdata`=0, `cpu_rstd`=0, `done`=0, `err`=0.
- All outputs are registered or decoded from the state register only. There is no combinational path from `in_valid`/`in_data` to any output.
- The 4th byte of a word is accepted at edge k. `im_we`=1 during cycle k..k+1. The memory write happens at edge k+1. `in_ready`=0 in that cycle.
- Minimum frame time for N words: 2 + 5N + 1 cycles with `in_valid` held high.
- Checksum byte accepted at edge c: `cpu_rstd`/`done` (or `err`) go high after edge c. No write is pending at that point.
- Gaps in `in_valid` simply stall. No timeout.
- `rstd` asserted mid-frame aborts immediately. `im_we` drops asynchronously and the next frame must start with MAGIC.

## Structure
- Shared package `loader_pkg`: state enum `ld_state_t`, `LD_MAGIC` = 8'hA5, `IM_AW` = 8.
- Single module. The byte-to-word packer (shift register plus 2-bit byte index) is inline logic, not a separate sub-module.
- Instantiated beside `computer`. `cpu_rstd` is ANDed with system `rstd` to form the core reset. A 2:1 mux gives the loader's write port priority into the instruction memory while `cpu_rstd`=0.

## Test plan
- Stream A5,01,12,34,56,78,08 -> one write addr 0 data 32'h12345678; `cpu_rstd`=1 and `done`=1 after the last byte; `err`=0.
- Bytes 00,FF,A5,02, words 00000001 and 00000002, then checksum 03 -> leading junk ignored; writes at addr 0,1; `done`=1.
- Bad checksum 00 for the first frame -> `err`=1, `cpu_rstd`=0. Then send a correct frame -> `err` clears, memory overwritten from addr 0, `done`=1.
- Count 00 with 256 random words -> addresses 0..255 each written once, no 257th write; correct XOR -> `done`=1.
- Random `in_valid` gaps during DATA -> same memory contents and write order as the gapless run; `in_ready`=0 exactly on S_WRITE cycles.
- `rstd` pulsed low after 2 data bytes -> all outputs return to reset values; a following full frame loads correctly from addr 0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
// Holds the FSM state encoding, the frame constants and the checksum fold.
package loader_pkg;

   localparam int         IM_AW    = 8;
   localparam logic [7:0] LD_MAGIC = 8'hA5;

   typedef enum logic [2:0] {
      S_MAGIC = 3'd0,
      S_COUNT = 3'd1,
      S_DATA  = 3'd2,
      S_WRITE = 3'd3,
      S_CHECK = 3'd4,
      S_RUN   = 3'd5,
      S_ERR   = 3'd6
   } ld_state_t;

   function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/imem_loader.sv
// Boot loader: unpacks a framed byte stream into 32-bit words for instruction
// memory and holds the CPU in reset until a frame with a good checksum lands.
module imem_loader
   import loader_pkg::*;
#(
   parameter int         AW    = IM_AW,
   parameter logic [7:0] MAGIC = LD_MAGIC
) (
   input  logic          clk,
   input  logic          rstd,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   output logic          im_we,
   output logic [AW-1:0] im_addr,
   output logic [31:0]   im_wdata,
   output logic          cpu_rstd,
   output logic          done,
   output logic          err
);

   ld_state_t      state_r;
   ld_state_t      state_s;
   logic           take_s;
   logic           ready_s;
   logic           we_s;
   logic           run_s;
   logic           err_s;
   logic [AW-1:0]  addr_r;
   logic [31:0]    wdata_r;
   logic [1:0]     idx_r;
   logic [8:0]     rem_r;
   logic [7:0]     csum_r;

   assign take_s = in_valid && ready_s;

   // State register
   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         state_r <= S_MAGIC;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic and output decode; outputs depend on state_r only
   always_comb begin
      state_s = state_r;
      ready_s = 1'b1;
      we_s    = 1'b0;
      run_s   = 1'b0;
      err_s   = 1'b0;
      case (state_r)
         S_MAGIC: begin
            if (take_s && (in_data == MAGIC)) state_s = S_COUNT;
            else                              state_s = S_MAGIC;
         end
         S_COUNT: begin
            if (take_s) state_s = S_DATA;
            else        state_s = S_COUNT;
         end
         S_DATA: begin
            if (take_s && (idx_r == 2'd3)) state_s = S_WRITE;
            else                           state_s = S_DATA;
         end
         S_WRITE: begin
            ready_s = 1'b0;
            we_s    = 1'b1;
            if (rem_r == 9'd1) state_s = S_CHECK;
            else               state_s = S_DATA;
         end
         S_CHECK: begin
            if (take_s) begin
               if (in_data == csum_r) state_s = S_RUN;
               else                   state_s = S_ERR;
            end else begin
               state_s = S_CHECK;
            end
         end
         S_RUN: begin
            ready_s = 1'b0;
            run_s   = 1'b1;
            state_s = S_RUN;
         end
         S_ERR: begin
            err_s = 1'b1;
            if (take_s && (in_data == MAGIC)) state_s = S_COUNT;
            else                              state_s = S_ERR;
         end
         default: begin
            state_s = S_MAGIC;
         end
      endcase
   end

   // Packer, checksum accumulator, address and remaining-word counter
   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         addr_r  <= '0;
         wdata_r <= 32'h0000_0000;
         idx_r   <= 2'd0;
         rem_r   <= 9'd0;
         csum_r  <= 8'h00;
      end else begin
         case (state_r)
            S_COUNT: begin
               if (take_s) begin
                  rem_r  <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
                  idx_r  <= 2'd0;
                  csum_r <= 8'h00;
                  addr_r <= '0;
               end
            end
            S_DATA: begin
               if (take_s) begin
                  wdata_r <= {wdata_r[23:0], in_data};
                  csum_r  <= csum_fold(csum_r, in_data);
                  idx_r   <= idx_r + 2'd1;
               end
            end
            S_WRITE: begin
               addr_r <= addr_r + AW'(1);
               rem_r  <= rem_r - 9'd1;
            end
            default: begin
            end
         endcase
      end
   end

   assign in_ready = ready_s;
   assign im_we    = we_s;
   assign im_addr  = addr_r;
   assign im_wdata = wdata_r;
   assign cpu_rstd = run_s;
   assign done     = run_s;
   assign err      = err_s;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: frames are streamed byte by
// byte and writes are captured into a memory model and an ordered log.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rstd = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready;
   logic        im_we;
   logic [7:0]  im_addr;
   logic [31:0] im_wdata;
   logic        cpu_rstd;
   logic        done;
   logic        err;

   int total = 0;
   int bad = 0;
   int ready_viol = 0;
   int gap_mode = 0;

   logic [7:0]  log_a[$];
   logic [31:0] log_d[$];
   logic [31:0] mem [256];

   imem_loader dut (
      .clk(clk), .rstd(rstd), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
      .cpu_rstd(cpu_rstd), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Write monitor, sampled mid-cycle; im_we lasts exactly one cycle per word
   always @(negedge clk) begin
      if (im_we === 1'b1) begin
         log_a.push_back(im_addr);
         log_d.push_back(im_wdata);
         mem[im_addr] = im_wdata;
      end
      if (in_ready !== !(im_we || done)) ready_viol++;
   end

   task automatic clear_log();
      log_a.delete();
      log_d.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid = 1'b0;
      rstd = 1'b0;
      repeat (2) @(negedge clk);
      rstd = 1'b1;
      @(negedge clk);
      clear_log();
   endtask

   task automatic send_byte(input logic [7:0] b);
      int guard;
      guard = 0;
      if (gap_mode != 0) begin
         in_valid = 1'b0;
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data = b;
      while (in_ready !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      total++;
      if (guard >= 50) begin
         bad++;
         $display("FAIL send_timeout in_ready=%b required=1", in_ready);
         in_valid = 1'b0;
      end else begin
         @(negedge clk);
      end
   endtask

   task automatic send_word(input logic [31:0] w);
      send_byte(w[31:24]);
      send_byte(w[23:16]);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   task automatic finish_stream();
      in_valid = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rstd = 1'b0;
      #12;
      total++;
      if ({in_ready, im_we, cpu_rstd, done, err} !== 5'b10000) begin
         bad++;
         $display("FAIL reset_flags got=%b required=10000", {in_ready, im_we, cpu_rstd, done, err});
      end
      total++;
      if (im_addr !== 8'h00 || im_wdata !== 32'h0) begin
         bad++;
         $display("FAIL reset_data addr=%h wdata=%h required 00/00000000", im_addr, im_wdata);
      end
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      send_byte(8'hA5); send_byte(8'h01); send_word(32'h12345678);
      total++;
      if (cpu_rstd !== 1'b0) begin
         bad++;
         $display("FAIL single_cpu_held got=%b required=0", cpu_rstd);
      end
      send_byte(8'h08);
      finish_stream();
      total++;
      if ({cpu_rstd, done, err} !== 3'b110) begin
         bad++;
         $display("FAIL single_status got=%b required=110", {cpu_rstd, done, err});
      end
      total++;
      if (log_a.size() != 1 || log_a[0] !== 8'h00 || log_d[0] !== 32'h12345678) begin
         bad++;
         $display("FAIL single_write count=%0d required 1 write 00:12345678", log_a.size());
      end
   endtask

   task automatic test_junk();
      do_reset();
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'hA5); send_byte(8'h02);
      send_word(32'h00000001); send_word(32'h00000002);
      send_byte(8'h03);
      finish_stream();
      total++;
      if (log_a.size() != 2) begin
         bad++;
         $display("FAIL junk_count got=%0d required=2", log_a.size());
      end else begin
         total++;
         if (log_a[0] !== 8'h00 || log_a[1] !== 8'h01 ||
             log_d[0] !== 32'h1 || log_d[1] !== 32'h2) begin
            bad++;
            $display("FAIL junk_writes got %h:%h %h:%h required 00:00000001 01:00000002",
                     log_a[0], log_d[0], log_a[1], log_d[1]);
         end
      end
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL junk_done got=%b required=1", done);
      end
   endtask

   task automatic test_bad_then_good();
      do_reset();
      send_byte(8'hA5); send_byte(8'h01); send_word(32'h12345678);
      send_byte(8'h00);
      finish_stream();
      total++;
      if ({err, cpu_rstd, done} !== 3'b100) begin
         bad++;
         $display("FAIL bad_status err/cpu/done=%b required=100", {err, cpu_rstd, done});
      end
      total++;
      if (mem[0] !== 32'h12345678) begin
         bad++;
         $display("FAIL bad_mem_kept got=%h required=12345678", mem[0]);
      end
      send_byte(8'h33);
      finish_stream();
      total++;
      if (err !== 1'b1) begin
         bad++;
         $display("FAIL err_hold got=%b required=1", err);
      end
      send_byte(8'hA5); send_byte(8'h01); send_word(32'hDEADBEEF);
      send_byte(8'h22);
      finish_stream();
      total++;
      if ({err, cpu_rstd, done} !== 3'b011) begin
         bad++;
         $display("FAIL retry_status err/cpu/done=%b required=011", {err, cpu_rstd, done});
      end
      total++;
      if (log_a.size() != 2 || log_a[1] !== 8'h00 || mem[0] !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL retry_write count=%0d mem0=%h required 2 writes, mem0=deadbeef",
                  log_a.size(), mem[0]);
      end
   endtask

   task automatic test_count256();
      logic [31:0] words [256];
      logic [7:0]  cs;
      int          errs;
      do_reset();
      cs = 8'h00;
      for (int i = 0; i < 256; i++) begin
         words[i] = $urandom;
         cs = cs ^ words[i][31:24] ^ words[i][23:16] ^ words[i][15:8] ^ words[i][7:0];
      end
      send_byte(8'hA5); send_byte(8'h00);
      for (int i = 0; i < 256; i++) send_word(words[i]);
      send_byte(cs);
      finish_stream();
      repeat (3) @(negedge clk);
      #1;
      total++;
      if (log_a.size() != 256) begin
         bad++;
         $display("FAIL full_count got=%0d required=256", log_a.size());
      end else begin
         errs = 0;
         for (int i = 0; i < 256; i++) begin
            if (log_a[i] !== 8'(i) || log_d[i] !== words[i]) errs++;
         end
         total++;
         if (errs != 0) begin
            bad++;
            $display("FAIL full_content bad_entries=%0d required=0", errs);
         end
      end
      total++;
      if ({done, err} !== 2'b10) begin
         bad++;
         $display("FAIL full_done done/err=%b required=10", {done, err});
      end
   endtask

   task automatic send_gap_frame();
      send_byte(8'hA5); send_byte(8'h04);
      send_word(32'h11223344); send_word(32'h55667788);
      send_word(32'h99AABBCC); send_word(32'hDDEEFF00);
      send_byte(8'h00);
      finish_stream();
   endtask

   task automatic test_gaps();
      logic [7:0]  ref_a[$];
      logic [31:0] ref_d[$];
      logic [31:0] exp_d [4];
      exp_d[0] = 32'h11223344; exp_d[1] = 32'h55667788;
      exp_d[2] = 32'h99AABBCC; exp_d[3] = 32'hDDEEFF00;
      do_reset();
      gap_mode = 0;
      send_gap_frame();
      ref_a = log_a;
      ref_d = log_d;
      total++;
      if (ref_a.size() != 4 || ref_d[0] !== exp_d[0] || ref_d[3] !== exp_d[3] || ref_a[3] !== 8'h03) begin
         bad++;
         $display("FAIL gapless_writes count=%0d required=4 ordered writes", ref_a.size());
      end
      do_reset();
      ready_viol = 0;
      gap_mode = 1;
      send_gap_frame();
      gap_mode = 0;
      total++;
      if (log_a != ref_a || log_d != ref_d) begin
         bad++;
         $display("FAIL gap_order count=%0d required=%0d identical writes", log_a.size(), ref_a.size());
      end
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL gap_done got=%b required=1", done);
      end
      total++;
      if (ready_viol != 0) begin
         bad++;
         $display("FAIL ready_decode violations=%0d required=0", ready_viol);
      end
   endtask

   task automatic test_abort();
      do_reset();
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h11); send_byte(8'h22);
      in_valid = 1'b0;
      rstd = 1'b0;
      #1;
      total++;
      if ({in_ready, im_we, cpu_rstd, done, err} !== 5'b10000 ||
          im_addr !== 8'h00 || im_wdata !== 32'h0) begin
         bad++;
         $display("FAIL abort_reset flags=%b addr=%h wdata=%h required 10000/00/00000000",
                  {in_ready, im_we, cpu_rstd, done, err}, im_addr, im_wdata);
      end
      @(negedge clk);
      rstd = 1'b1;
      @(negedge clk);
      clear_log();
      send_byte(8'h33); send_byte(8'h44);
      send_byte(8'hA5); send_byte(8'h01); send_word(32'hCAFEBABE);
      send_byte(8'h30);
      finish_stream();
      total++;
      if (log_a.size() != 1 || log_a[0] !== 8'h00 || log_d[0] !== 32'hCAFEBABE || done !== 1'b1) begin
         bad++;
         $display("FAIL abort_reload count=%0d done=%b required 1 write 00:cafebabe done=1",
                  log_a.size(), done);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_junk();
      test_bad_then_good();
      test_count256();
      test_gaps();
      test_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
